// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN          : default data/address width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) shown when no instruction is valid
//   fetch_state_t : fetch FSM states (S_REQ issues a request, S_WAIT awaits its response)
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        S_REQ,
        S_WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction + PC buffer feeding the IF/ID register.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   load          : capture load_instr/load_pc and mark the entry valid
//   clear         : flush the entry (redirect); wins over load and consume
//   consume       : downstream took the entry this cycle
//   load_instr    : instruction word to capture
//   load_pc       : address the instruction was fetched from
//   valid         : entry holds a real fetched instruction
//   instr         : buffered instruction, NOP when not valid
//   pc            : PC of the buffered instruction
module fetch_buf #(
    parameter int unsigned          XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic            consume,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);
    import riscv_pkg::*;

    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload registers are reset as well so if_pc reads
            // RESET_PC straight out of reset; correctness only needs valid_q.
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            // A reload in the same cycle as a consume keeps the entry valid.
            valid_q <= 1'b1;
            instr_q <= load_instr;
            pc_q    <= load_pc;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    // Outputs depend only on buffer registers, never on module inputs.
    assign valid = valid_q;
    assign instr = valid_q ? instr_q : NOP_INSTR;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: write side of the IF/ID pipeline register.
// Holds the PC, issues one outstanding instruction-memory request at a time,
// buffers the response and presents it downstream; honours stall and redirect.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   imem_req_valid  : request to instruction memory
//   imem_req_ready  : memory accepts the request this cycle
//   imem_req_addr   : fetch address (always the current pc)
//   imem_rsp_valid  : response data valid
//   imem_rsp_data   : instruction word
//   stall           : IF/ID register not loading this cycle
//   redirect        : branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc     : redirect target, fetched as given (alignment checked later)
//   if_instr        : instruction to IF/ID, NOP when ~if_valid
//   if_pc           : PC of if_instr
//   if_valid        : if_instr is a real fetched instruction
module fetch_unit #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_valid
);
    import riscv_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            drop;

    logic buf_valid;
    logic consume;
    logic req_fire;
    logic rsp_take;
    logic buf_load;

    assign consume = buf_valid & ~stall;

    // A new request may only go out when the buffer will be free to take its
    // response; reset and redirect suppress it for the current cycle.
    assign imem_req_valid = ~rst & ~redirect & (state == S_REQ) & (~buf_valid | consume);
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_take = (state == S_WAIT) & imem_rsp_valid;
    assign buf_load = ~rst & ~redirect & rsp_take & ~drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= S_REQ;
            drop  <= 1'b0;
        end else if (redirect) begin
            pc <= redirect_pc;
            if (state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    // The in-flight response arrives now and is discarded.
                    state <= S_REQ;
                    drop  <= 1'b0;
                end else begin
                    // Remember to discard the response still in flight.
                    drop <= 1'b1;
                end
            end
        end else if (req_fire) begin
            pc    <= pc + XLEN'(4);
            state <= S_WAIT;
        end else if (rsp_take) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end
    end

    // While waiting with drop clear, pc is exactly the sent address plus 4
    // (modulo 2^XLEN), so the sent address is recovered without a register.
    fetch_buf #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (redirect),
        .consume    (consume),
        .load_instr (imem_rsp_data),
        .load_pc    (pc - XLEN'(4)),
        .valid      (buf_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign if_valid = buf_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    // ---------------- instruction memory ----------------
    int          mem_lat = 1;
    bit          mem_pending = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;

    // Advance one clock: observe the request handshake late in the cycle,
    // then drive the memory response for the next cycle just after the edge.
    task automatic tick();
        bit          fire;
        bit          was_rst;
        logic [31:0] a;
        @(negedge clk);
        fire    = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
        a       = imem_req_addr;
        was_rst = rst;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (was_rst) begin
            mem_pending = 1'b0;
        end else if (fire) begin
            mem_pending = 1'b1;
            mem_wait    = mem_lat;
            mem_addr    = a;
        end
        if (mem_pending) begin
            mem_wait--;
            if (mem_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pending    = 1'b0;
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_buf[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_fly_addr = '0;
    bit          m_fly = 1'b0;
    bit          m_keep = 1'b0;
    bit          model_live = 1'b0;

    function automatic bit exp_req();
        return !rst && !redirect && !m_fly && (m_buf.size() == 0 || !stall);
    endfunction

    always @(posedge clk) begin : model
        bit fire;
        bit consume;
        if (rst) begin
            m_pc   = RST_PC;
            m_fly  = 1'b0;
            m_keep = 1'b0;
            m_buf.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            fire    = exp_req() && imem_req_ready;
            consume = (m_buf.size() != 0) && !stall;
            if (redirect) begin
                m_pc = redirect_pc;
                m_buf.delete();
                if (m_fly) begin
                    if (imem_rsp_valid) m_fly = 1'b0;
                    else m_keep = 1'b0;
                end
            end else begin
                if (consume) void'(m_buf.pop_front());
                if (m_fly && imem_rsp_valid) begin
                    m_fly = 1'b0;
                    if (m_keep) m_buf.push_back('{mem_word(m_fly_addr), m_fly_addr});
                end
                if (fire) begin
                    m_fly      = 1'b1;
                    m_keep     = 1'b1;
                    m_fly_addr = m_pc;
                    m_pc       = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req()});
            check("req_addr", imem_req_addr, m_pc);
            check("if_valid", {31'b0, if_valid}, {31'b0, m_buf.size() != 0});
            if (m_buf.size() != 0) begin
                check("if_pc", if_pc, m_buf[0].pc);
                check("if_instr", if_instr, m_buf[0].instr);
            end else begin
                check("if_instr_nop", if_instr, NOP_INSTR);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset held two cycles.
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            check("rst_if_valid", {31'b0, if_valid}, 32'd0);
            check("rst_if_instr", if_instr, 32'h0000_0013);
            check("rst_if_pc", if_pc, 32'h0);
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rel_req_addr", imem_req_addr, 32'h0);

        // Streaming, 1-cycle memory: valid every other cycle at 0,4,8,12.
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            check("stream_valid", {31'b0, if_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                check("stream_pc", if_pc, 32'(4 * (k / 2 - 1)));
                check("stream_instr", if_instr, mem_word(32'(4 * (k / 2 - 1))));
            end
        end

        // Stall five cycles with the buffer holding pc 0x8.
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        stall = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                #1;
            end
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, mem_word(32'h8));
            check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        tick();
        stall = 1'b0;
        #1;
        check("unstall_req", {31'b0, imem_req_valid}, 32'd1);
        check("unstall_addr", imem_req_addr, 32'hC);

        // Redirect while waiting on a 3-cycle response for 0x10.
        tick();
        tick();
        mem_lat = 3;
        #1;
        check("w_req_10", imem_req_addr, 32'h10);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("w_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("w_wait_valid", {31'b0, if_valid}, 32'd0);
        check("w_wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        #1;
        check("w_rsp_valid", {31'b0, if_valid}, 32'd0);
        tick();
        mem_lat = 1;
        #1;
        check("w_dropped", {31'b0, if_valid}, 32'd0);
        check("w_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("w_req_addr", imem_req_addr, 32'h100);

        // Redirect while the buffer holds 0x20 under stall.
        tick();
        tick();
        #1;
        check("b_pc_100", if_pc, 32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        #1;
        check("b_req_20", imem_req_addr, 32'h20);
        tick();
        tick();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("b_hold_valid", {31'b0, if_valid}, 32'd1);
        check("b_hold_pc", if_pc, 32'h20);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        check("b_flush_valid", {31'b0, if_valid}, 32'd0);
        check("b_flush_nop", if_instr, 32'h0000_0013);
        check("b_req_40", imem_req_addr, 32'h40);
        check("b_req_valid", {31'b0, imem_req_valid}, 32'd1);
        tick();
        tick();
        #1;
        check("b_pc_40", if_pc, 32'h40);

        // Backpressure at the top of the address space, then wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                #1;
            end
            check("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("bp_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        end
        tick();
        imem_req_ready = 1'b1;
        #1;
        check("wrap_accept_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        check("wrap_addr0", imem_req_addr, 32'h0);
        tick();
        #1;
        check("wrap_buf_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_buf_instr", if_instr, mem_word(32'hFFFF_FFFC));
        check("wrap_next_req", {31'b0, imem_req_valid}, 32'd1);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst      = ($urandom_range(0, 199) == 0);
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'h0000_0FFC;
            endcase
            imem_req_ready = ($urandom_range(0, 99) < 70);
            mem_lat        = $urandom_range(1, 4);
        end
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
